// File: rtl/mc_controller_pkg.sv
// Shared types and select codes for the multicycle controller.
// Holds the main FSM state enum, the ALU/mux encodings and the per-state output table.
package mc_controller_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, UNKNOWN
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] SRCA_A   = 2'b00;
  localparam logic [1:0] SRCA_PC  = 2'b01;
  localparam logic [1:0] SRCB_RD2 = 2'b00;
  localparam logic [1:0] SRCB_IMM = 2'b01;
  localparam logic [1:0] SRCB_4   = 2'b10;
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  typedef struct packed {
    logic       irwrite;
    logic       nextpc;
    logic       adrsrc;
    logic       regw;
    logic       memw;
    logic       aluop;
    logic       branch;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
  } fsm_out_t;

  function automatic fsm_out_t state_outputs(state_t s);
    fsm_out_t o;
    o = '0;
    case (s)
      FETCH: begin
        o.irwrite = 1'b1; o.nextpc = 1'b1;
        o.alusrca = SRCA_PC; o.alusrcb = SRCB_4; o.resultsrc = RES_ALURESULT;
      end
      DECODE: begin
        o.alusrca = SRCA_PC; o.alusrcb = SRCB_4; o.resultsrc = RES_ALURESULT;
      end
      MEMADR: o.alusrcb = SRCB_IMM;
      MEMRD:  o.adrsrc = 1'b1;
      MEMWB:  begin o.resultsrc = RES_DATA; o.regw = 1'b1; end
      MEMWR:  begin o.adrsrc = 1'b1; o.memw = 1'b1; end
      EXECR:  o.aluop = 1'b1;
      EXECI:  begin o.alusrcb = SRCB_IMM; o.aluop = 1'b1; end
      ALUWB:  o.regw = 1'b1;
      BRANCH: begin o.alusrcb = SRCB_IMM; o.resultsrc = RES_ALURESULT; o.branch = 1'b1; end
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Instruction/flag inputs and datapath control outputs of the multicycle controller.
interface mc_controller_if;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite;
  logic        MemWrite;
  logic        RegWrite;
  logic        IRWrite;
  logic        AdrSrc;
  logic [1:0]  RegSrc;
  logic [1:0]  ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ResultSrc;
  logic [1:0]  ImmSrc;
  logic [1:0]  ALUControl;

  modport master (
    output Instr, ALUFlags,
    input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc,
    input  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl
  );

  modport slave (
    input  Instr, ALUFlags,
    output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc,
    output RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl
  );
endinterface

// File: rtl/mc_controller_mainfsm.sv
// Main sequencing FSM: state register plus registered per-state control outputs.
//  state   | meaning
//  FETCH   | load IR, PC <= PC+4
//  DECODE  | read registers, pick instruction class
//  MEMADR  | compute load/store address
//  MEMRD   | read data memory
//  MEMWB   | write loaded data to register file
//  MEMWR   | write data memory
//  EXECR   | ALU op, register operand
//  EXECI   | ALU op, immediate operand
//  ALUWB   | write ALU result
//  BRANCH  | conditional PC update
//  UNKNOWN | undefined op, no side effects
module mc_mainfsm
  import mc_controller_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic [1:0] op,
  input  logic     is_imm,
  input  logic     is_load,
  output state_t   state,
  output fsm_out_t ctl
);

  function automatic state_t next_state(state_t s, logic [1:0] o, logic imm, logic ld);
    case (s)
      FETCH:  return DECODE;
      DECODE: case (o)
                2'b00:   return imm ? EXECI : EXECR;
                2'b01:   return MEMADR;
                2'b10:   return BRANCH;
                default: return UNKNOWN;
              endcase
      MEMADR: return ld ? MEMRD : MEMWR;
      MEMRD:  return MEMWB;
      EXECR,
      EXECI:  return ALUWB;
      default: return FETCH;
    endcase
  endfunction

  // Outputs are registered from the next state so they change on the same edge as state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
      ctl   <= state_outputs(FETCH);
    end else begin
      state <= next_state(state, op, is_imm, is_load);
      ctl   <= state_outputs(next_state(state, op, is_imm, is_load));
    end
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle ARM-subset controller: instruction decode, ALU decode, condition check and flags.
module mc_controller
  import mc_controller_pkg::*;
(
  input  logic clk,
  input  logic reset,
  mc_controller_if.slave bus
);

  logic [3:0] cond, rd;
  logic [1:0] op;
  logic [5:0] funct;
  state_t     state;
  fsm_out_t   ctl;
  logic [3:0] flags;
  logic [1:0] flagw;
  logic [1:0] alucontrol;
  logic       condex, condexr;
  logic       unused;

  assign cond   = bus.Instr[31:28];
  assign op     = bus.Instr[27:26];
  assign funct  = bus.Instr[25:20];
  assign rd     = bus.Instr[15:12];
  assign unused = ^{bus.Instr[19:16], bus.Instr[11:0]};

  mc_mainfsm u_mainfsm (
    .clk     (clk),
    .reset   (reset),
    .op      (op),
    .is_imm  (funct[5]),
    .is_load (funct[0]),
    .state   (state),
    .ctl     (ctl)
  );

  always_comb begin
    alucontrol = ALU_ADD;
    flagw      = 2'b00;
    if (ctl.aluop) begin
      case (funct[4:1])
        4'b0100: begin alucontrol = ALU_ADD; flagw = {2{funct[0]}}; end
        4'b0010: begin alucontrol = ALU_SUB; flagw = {2{funct[0]}}; end
        4'b0000: begin alucontrol = ALU_AND; flagw = {funct[0], 1'b0}; end
        4'b1100: begin alucontrol = ALU_ORR; flagw = {funct[0], 1'b0}; end
        default: begin alucontrol = ALU_ADD; flagw = 2'b00; end
      endcase
    end
  end

  always_comb begin
    logic n, z, c, v;
    {n, z, c, v} = flags;
    case (cond)
      4'b0000: condex = z;
      4'b0001: condex = ~z;
      4'b0010: condex = c;
      4'b0011: condex = ~c;
      4'b0100: condex = n;
      4'b0101: condex = ~n;
      4'b0110: condex = v;
      4'b0111: condex = ~v;
      4'b1000: condex = c & ~z;
      4'b1001: condex = ~c | z;
      4'b1010: condex = (n == v);
      4'b1011: condex = (n != v);
      4'b1100: condex = ~z & (n == v);
      4'b1101: condex = z | (n != v);
      4'b1110: condex = 1'b1;
      default: condex = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags   <= 4'b0000;
      condexr <= 1'b0;
    end else begin
      if (state == DECODE) condexr <= condex;
      if (flagw[1] && condex) flags[3:2] <= bus.ALUFlags[3:2];
      if (flagw[0] && condex) flags[1:0] <= bus.ALUFlags[1:0];
    end
  end

  assign bus.PCWrite    = ctl.nextpc | (ctl.branch & condexr) | ((rd == 4'hF) & ctl.regw & condexr);
  assign bus.RegWrite   = ctl.regw & condexr;
  assign bus.MemWrite   = ctl.memw & condexr;
  assign bus.IRWrite    = ctl.irwrite;
  assign bus.AdrSrc     = ctl.adrsrc;
  assign bus.ALUSrcA    = ctl.alusrca;
  assign bus.ALUSrcB    = ctl.alusrcb;
  assign bus.ResultSrc  = ctl.resultsrc;
  assign bus.ALUControl = alucontrol;
  assign bus.ImmSrc     = op;
  assign bus.RegSrc     = {op == 2'b01, op == 2'b10};

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: directed instruction sequences then random instructions
// compared cycle by cycle against an instruction-level reference model.
module tb_mc_controller;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;
  logic [3:0] m_flags = 4'b0000;

  mc_controller_if bus();

  mc_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef enum logic [3:0] {
    S_F, S_D, S_MA, S_MR, S_MWB, S_MW, S_ER, S_EI, S_AWB, S_BR, S_UN
  } step_t;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // ARM conditions as an even/odd pair: odd codes invert the base test.
  function automatic bit cond_holds(logic [3:0] cond, logic [3:0] f);
    bit n, z, c, v, base;
    {n, z, c, v} = f;
    if (cond == 4'hF) return 1'b0;
    case (cond[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return base ^ cond[0];
  endfunction

  function automatic logic [1:0] alu_code(logic [3:0] f41);
    case (f41)
      4'b0100: return 2'd0;
      4'b0010: return 2'd1;
      4'b0000: return 2'd2;
      4'b1100: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [16:0] obs_vec();
    return {bus.PCWrite, bus.MemWrite, bus.RegWrite, bus.IRWrite, bus.AdrSrc, bus.RegSrc,
            bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.ImmSrc, bus.ALUControl};
  endfunction

  function automatic logic [16:0] expect_vec(step_t s, logic [31:0] instr, bit cex);
    logic pcw, memw, regw, irw, adr;
    logic [1:0] srca, srcb, res, ctl, op, regsrc;
    bit pcs;
    {pcw, memw, regw, irw, adr} = 5'b0;
    {srca, srcb, res, ctl} = 8'b0;
    op = instr[27:26];
    regsrc = {op == 2'b01, op == 2'b10};
    pcs = (instr[15:12] == 4'hF);
    case (s)
      S_F:   begin irw = 1; pcw = 1; srca = 2'b01; srcb = 2'b10; res = 2'b10; end
      S_D:   begin srca = 2'b01; srcb = 2'b10; res = 2'b10; end
      S_MA:  srcb = 2'b01;
      S_MR:  adr = 1;
      S_MWB: begin res = 2'b01; regw = cex; pcw = pcs && cex; end
      S_MW:  begin adr = 1; memw = cex; end
      S_ER:  ctl = alu_code(instr[24:21]);
      S_EI:  begin srcb = 2'b01; ctl = alu_code(instr[24:21]); end
      S_AWB: begin regw = cex; pcw = pcs && cex; end
      S_BR:  begin srcb = 2'b01; res = 2'b10; pcw = cex; end
      default: ;
    endcase
    return {pcw, memw, regw, irw, adr, regsrc, srca, srcb, res, op, ctl};
  endfunction

  // Runs one instruction from FETCH; entry and exit are just after a rising edge in FETCH.
  task automatic run_instr(string tag, logic [31:0] instr, bit force_fl, logic [3:0] fl,
                           int abort_step);
    step_t steps[$];
    logic [1:0] op = instr[27:26];
    logic [5:0] funct = instr[25:20];
    logic [3:0] fl_now;
    bit cex;
    steps = '{S_F, S_D};
    case (op)
      2'b00: begin steps.push_back(funct[5] ? S_EI : S_ER); steps.push_back(S_AWB); end
      2'b01: begin
        steps.push_back(S_MA);
        if (funct[0]) begin steps.push_back(S_MR); steps.push_back(S_MWB); end
        else steps.push_back(S_MW);
      end
      2'b10: steps.push_back(S_BR);
      default: steps.push_back(S_UN);
    endcase
    cex = cond_holds(instr[31:28], m_flags);
    bus.Instr = instr;
    foreach (steps[i]) begin
      fl_now = force_fl ? fl : 4'($urandom);
      bus.ALUFlags = fl_now;
      @(negedge clk);
      check($sformatf("%s_%s_c%0d", tag, steps[i].name(), i), 32'(obs_vec()),
            32'(expect_vec(steps[i], instr, cex)));
      if (i == abort_step) begin
        reset = 1'b0;
        #1;
        check({tag, "_abort_memwrite"}, 32'(bus.MemWrite), 32'd0);
        check({tag, "_abort_outputs"}, 32'(obs_vec()), 32'(expect_vec(S_F, instr, 1'b0)));
        m_flags = 4'b0000;
        @(posedge clk);
        #1;
        reset = 1'b1;
        return;
      end
      if ((steps[i] == S_ER || steps[i] == S_EI) && funct[0] && cex) begin
        case (funct[4:1])
          4'b0100, 4'b0010: m_flags = fl_now;
          4'b0000, 4'b1100: m_flags[3:2] = fl_now[3:2];
          default: ;
        endcase
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [31:0] r;
    bus.Instr = 32'h0;
    bus.ALUFlags = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 32'(obs_vec()), 32'(expect_vec(S_F, 32'h0, 1'b0)));
    @(posedge clk);
    #1;
    reset = 1'b1;

    run_instr("add", 32'hE0821003, 1'b0, 4'h0, -1);
    run_instr("ldr", 32'hE5921004, 1'b0, 4'h0, -1);
    run_instr("str", 32'hE5821004, 1'b0, 4'h0, -1);
    run_instr("subs_z", 32'hE0521003, 1'b1, 4'b0110, -1);
    run_instr("beq_taken", 32'h0A000002, 1'b0, 4'h0, -1);
    run_instr("subs_nz", 32'hE0521003, 1'b1, 4'b0000, -1);
    run_instr("beq_not", 32'h0A000002, 1'b0, 4'h0, -1);
    run_instr("subs_z2", 32'hE0521003, 1'b1, 4'b0110, -1);
    run_instr("addne", 32'h10821003, 1'b1, 4'b1001, -1);
    run_instr("beq_held", 32'h0A000002, 1'b0, 4'h0, -1);
    run_instr("subs_z3", 32'hE0521003, 1'b1, 4'b0110, -1);
    run_instr("str_abort", 32'hE5821004, 1'b0, 4'h0, 3);
    run_instr("beq_after_rst", 32'h0A000002, 1'b0, 4'h0, -1);
    run_instr("bcs_after_rst", 32'h2A000002, 1'b0, 4'h0, -1);

    for (int k = 0; k < 120; k++) begin
      r = $urandom;
      if ($urandom_range(1, 0) == 1) r[31:28] = 4'hE;
      if ($urandom_range(3, 0) == 0) r[15:12] = 4'hF;
      run_instr($sformatf("rnd%0d", k), r, 1'b0, 4'h0, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
